// File: rtl/exc_seq.sv
// Exception/interrupt sequencer: CP0 SR/Cause/EPC/PRId, trap/return decision on the MEM-stage instruction.
// Latency: kill_M combinational in the detect cycle; exception/eret/flush a registered one-cycle pulse the cycle after.
// Backpressure: none; MEM inputs are ignored for the one redirect cycle. Optional macro: EXC_SEQ_BD_EPC_EN.
module exc_seq #(
    parameter logic [31:0] PRID = 32'h2017_1205
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_M,
    input  logic [31:0] pc_M,
    input  logic        bd_M,
    input  logic [4:0]  exc_M,
    input  logic        eret_M,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [5:0]  hw_int,
    output logic [31:0] cp0_rdata,
    output logic        kill_M,
    output logic        exception,
    output logic        eret,
    output logic [31:0] epc,
    output logic        flush
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_TRAP = 2'd1,
        S_RET  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // CP0 architectural state
    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [4:0]  code_q;
    logic [31:0] epc_q;

    // Two-flop synchronizer for the asynchronous interrupt lines; ip_q is Cause.IP
    logic [5:0]  int_s1_q;
    logic [5:0]  ip_q;

    logic        mem_live;
    logic        int_req;
    logic        take_int;
    logic        take_exc;
    logic        take_trap;
    logic        take_ret;
    logic        do_mtc0;
    logic [4:0]  trap_code;
    logic [31:0] cap_pc;
    logic        bd_in;

    // Only a real instruction seen in RUN can trap or return; reset masks the combinational kill
    assign mem_live  = (state_q == S_RUN) && valid_M && !reset;
    assign int_req   = ie_q && !exl_q && (|(ip_q & im_q));
    assign take_int  = mem_live && int_req;
    assign take_exc  = mem_live && !int_req && (exc_M != 5'd0);
    assign take_trap = take_int || take_exc;
    assign take_ret  = mem_live && !take_trap && eret_M;
    // A redirect in the same cycle swallows the mtc0, as the instruction is being killed
    assign do_mtc0   = (state_q == S_RUN) && cp0_we && !take_trap && !take_ret;
    assign trap_code = take_int ? 5'd0 : exc_M;

`ifdef EXC_SEQ_BD_EPC_EN
    // Point EPC at the branch so the return re-executes it
    assign cap_pc = bd_M ? (pc_M - 32'd4) : pc_M;
    assign bd_in  = bd_M;
`else
    logic unused_bd;
    assign unused_bd = bd_M;
    assign cap_pc    = pc_M;
    assign bd_in     = 1'b0;
`endif

    // Synchronize hw_int into the Cause.IP field
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_s1_q <= 6'd0;
            ip_q     <= 6'd0;
        end else begin
            int_s1_q <= hw_int;
            ip_q     <= int_s1_q;
        end
    end

    // CP0 register updates: trap capture, return EXL clear, or mtc0 write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q   <= 6'd0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            code_q <= 5'd0;
            epc_q  <= 32'd0;
        end else if (take_trap) begin
            exl_q  <= 1'b1;
            code_q <= trap_code;
            bd_q   <= bd_in;
            epc_q  <= cap_pc;
        end else if (take_ret) begin
            exl_q  <= 1'b0;
        end else if (do_mtc0) begin
            case (cp0_addr)
                5'd12: begin
                    im_q  <= cp0_wdata[15:10];
                    exl_q <= cp0_wdata[1];
                    ie_q  <= cp0_wdata[0];
                end
                5'd14:   epc_q <= cp0_wdata;
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: redirect states last exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (take_trap) begin
                    state_d = S_TRAP;
                end else if (take_ret) begin
                    state_d = S_RET;
                end
            end
            S_TRAP:  state_d = S_RUN;
            S_RET:   state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Outputs: redirect pulses decode the state, kill follows the trap decision
    always_comb begin
        exception = (state_q == S_TRAP);
        eret      = (state_q == S_RET);
        flush     = (state_q == S_TRAP) || (state_q == S_RET);
        kill_M    = take_trap;
    end

    // mfc0 read mux, pre-edge values only
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            5'd12:   cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
            5'd13:   cp0_rdata = {bd_q, 15'd0, ip_q, 3'd0, code_q, 2'd0};
            5'd14:   cp0_rdata = epc_q;
            5'd15:   cp0_rdata = PRID;
            default: cp0_rdata = 32'd0;
        endcase
    end

    assign epc = epc_q;

endmodule
